// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and elaboration helpers
// used by the raster timing generator and its per-axis counters.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Smallest coordinate width able to hold 0..max(total)-1 on both axes.
    function automatic int min_cw(input int h_total, input int v_total);
        int m;
        m = (h_total > v_total) ? h_total : v_total;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and
// active-region decode that always match the current coordinate.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POS    = 1'b0,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          step,
    output logic [CW-1:0] coord,
    output logic          sync,
    output logic          active,
    output logic          last
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST_C  = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);

    logic [CW-1:0] nxt;
    logic          nxt_in_sync;

    assign last = (coord == LAST_C);

    // Decode from the next coordinate so the flopped sync/active line up with coord.
    always_comb begin
        nxt = coord;
        if (step) begin
            nxt = last ? '0 : coord + 1'b1;
        end
        nxt_in_sync = (nxt >= SYNC_LO) && (nxt <= SYNC_HI);
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            coord  <= '0;
            sync   <= ~POS;
            active <= 1'b1;
        end else begin
            coord  <= nxt;
            sync   <= ~(nxt_in_sync ^ POS);
            active <= (nxt < ACT_END);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, chained
// horizontal/vertical axis counters, display enable and start-of-frame pulse.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POS   = 1'b0,
    parameter bit VS_POS   = 1'b0,
    parameter int CLK_DIV  = 1,
    parameter int CW       = 10
) (
    input  logic          CLK,
    input  logic          aclr_i,
    input  logic          run_i,
    output logic          pix_tick_o,
    output logic [CW-1:0] HCOORD,
    output logic [CW-1:0] VCOORD,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          DE,
    output logic          Hrollover_o,
    output logic          Vrollover_o,
    output logic          sof_o
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_width
        $error("vga_timing_gen: every porch/sync/active width must be at least 1");
    end
    if (min_cw(H_TOTAL, V_TOTAL) > CW) begin : g_bad_cw
        $error("vga_timing_gen: CW too small for the line/frame totals");
    end

    logic [DW-1:0] div;
    logic          h_last;
    logic          v_last;
    logic          h_active;
    logic          v_active;

    assign pix_tick_o  = run_i && (div == DIV_LAST);
    assign Hrollover_o = pix_tick_o && h_last;
    assign Vrollover_o = Hrollover_o && v_last;
    assign DE          = h_active && v_active;

    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            div <= '0;
        end else if (run_i) begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    // Vrollover_o already reads 0 while paused, so sof_o stays a single-cycle pulse.
    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            sof_o <= 1'b0;
        end else begin
            sof_o <= Vrollover_o;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POS    (HS_POS),
        .CW     (CW)
    ) u_h (
        .clk    (CLK),
        .aclr   (aclr_i),
        .step   (pix_tick_o),
        .coord  (HCOORD),
        .sync   (HSYNC),
        .active (h_active),
        .last   (h_last)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POS    (VS_POS),
        .CW     (CW)
    ) u_v (
        .clk    (CLK),
        .aclr   (aclr_i),
        .step   (Hrollover_o),
        .coord  (VCOORD),
        .sync   (VSYNC),
        .active (v_active),
        .last   (v_last)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default H with short V, CLK_DIV=4,
// tiny active-high mode) checked against a closed-form timing model.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hsy, hb, va, vf, vsy, vb;
        bit hp, vp;
        int div;
    } mode_t;

    typedef struct {
        int h, v;
        bit hs, vs, de, tick, hroll, vroll, sof;
    } obs_t;

    typedef struct {
        int   k;
        obs_t o;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       aclr_a, run_a, tick_a, hs_a, vs_a, de_a, hr_a, vr_a, sof_a;
    logic [9:0] hc_a, vc_a;
    logic       aclr_b, run_b, tick_b, hs_b, vs_b, de_b, hr_b, vr_b, sof_b;
    logic [9:0] hc_b, vc_b;
    logic       aclr_c, run_c, tick_c, hs_c, vs_c, de_c, hr_c, vr_c, sof_c;
    logic [2:0] hc_c, vc_c;

    vga_timing_gen #(
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2)
    ) dut_a (
        .CLK (clk), .aclr_i (aclr_a), .run_i (run_a), .pix_tick_o (tick_a),
        .HCOORD (hc_a), .VCOORD (vc_a), .HSYNC (hs_a), .VSYNC (vs_a), .DE (de_a),
        .Hrollover_o (hr_a), .Vrollover_o (vr_a), .sof_o (sof_a)
    );

    vga_timing_gen #(
        .CLK_DIV (4)
    ) dut_b (
        .CLK (clk), .aclr_i (aclr_b), .run_i (run_b), .pix_tick_o (tick_b),
        .HCOORD (hc_b), .VCOORD (vc_b), .HSYNC (hs_b), .VSYNC (vs_b), .DE (de_b),
        .Hrollover_o (hr_b), .Vrollover_o (vr_b), .sof_o (sof_b)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POS (1'b1), .VS_POS (1'b1), .CW (3)
    ) dut_c (
        .CLK (clk), .aclr_i (aclr_c), .run_i (run_c), .pix_tick_o (tick_c),
        .HCOORD (hc_c), .VCOORD (vc_c), .HSYNC (hs_c), .VSYNC (vs_c), .DE (de_c),
        .Hrollover_o (hr_c), .Vrollover_o (vr_c), .sof_o (sof_c)
    );

    int    checks   = 0;
    int    failures = 0;
    obs_t  exp_q[$];
    mode_t ma, mb, mc;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic compare(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".hcoord"}, a.h, e.h);
        chk({tag, ".vcoord"}, a.v, e.v);
        chk({tag, ".hsync"}, int'(a.hs), int'(e.hs));
        chk({tag, ".vsync"}, int'(a.vs), int'(e.vs));
        chk({tag, ".de"}, int'(a.de), int'(e.de));
        chk({tag, ".tick"}, int'(a.tick), int'(e.tick));
        chk({tag, ".hroll"}, int'(a.hroll), int'(e.hroll));
        chk({tag, ".vroll"}, int'(a.vroll), int'(e.vroll));
        chk({tag, ".sof"}, int'(a.sof), int'(e.sof));
    endtask

    // Expected outputs after j clock edges with run high since reset, run high now.
    function automatic obs_t model(input mode_t m, input int j);
        obs_t o;
        int ht, vt, t;
        ht = m.ha + m.hf + m.hsy + m.hb;
        vt = m.va + m.vf + m.vsy + m.vb;
        t  = j / m.div;
        o.h     = t % ht;
        o.v     = (t / ht) % vt;
        o.tick  = (j % m.div) == m.div - 1;
        o.hroll = o.tick && (o.h == ht - 1);
        o.vroll = o.hroll && (o.v == vt - 1);
        o.hs    = (o.h >= m.ha + m.hf && o.h < m.ha + m.hf + m.hsy) ? m.hp : !m.hp;
        o.vs    = (o.v >= m.va + m.vf && o.v < m.va + m.vf + m.vsy) ? m.vp : !m.vp;
        o.de    = (o.h < m.ha) && (o.v < m.va);
        o.sof   = (j > 0) && (j % m.div == 0) && (t % (ht * vt) == 0);
        return o;
    endfunction

    function automatic obs_t paused(input obs_t e);
        obs_t o;
        o = e;
        o.tick = 1'b0; o.hroll = 1'b0; o.vroll = 1'b0; o.sof = 1'b0;
        return o;
    endfunction

    function automatic obs_t sample(input int sel);
        obs_t o;
        case (sel)
            0: begin
                o.h = int'(hc_a); o.v = int'(vc_a); o.hs = hs_a; o.vs = vs_a; o.de = de_a;
                o.tick = tick_a; o.hroll = hr_a; o.vroll = vr_a; o.sof = sof_a;
            end
            1: begin
                o.h = int'(hc_b); o.v = int'(vc_b); o.hs = hs_b; o.vs = vs_b; o.de = de_b;
                o.tick = tick_b; o.hroll = hr_b; o.vroll = vr_b; o.sof = sof_b;
            end
            default: begin
                o.h = int'(hc_c); o.v = int'(vc_c); o.hs = hs_c; o.vs = vs_c; o.de = de_c;
                o.tick = tick_c; o.hroll = hr_c; o.vroll = vr_c; o.sof = sof_c;
            end
        endcase
        return o;
    endfunction

    function automatic vec_t mkv(input int k, input int h, input int v, input bit hs, input bit vs,
                                 input bit de, input bit hr, input bit vr, input bit sof);
        vec_t r;
        r.k = k;
        r.o.h = h; r.o.v = v; r.o.hs = hs; r.o.vs = vs; r.o.de = de;
        r.o.tick = 1'b1; r.o.hroll = hr; r.o.vroll = vr; r.o.sof = sof;
        return r;
    endfunction

    // One clock with run held high: expectation queued after the edge, checked 1 ns later.
    task automatic step_check(input int sel, input mode_t m, input string tag, inout int j);
        obs_t e;
        @(posedge clk);
        j++;
        #1;
        exp_q.push_back(model(m, j));
        #1;
        e = exp_q.pop_front();
        compare(tag, sample(sel), e);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        int   ja, jb, jc;

        ma = '{ha:640, hf:16, hsy:96, hb:48, va:6, vf:2, vsy:2, vb:2, hp:1'b0, vp:1'b0, div:1};
        mb = '{ha:640, hf:16, hsy:96, hb:48, va:480, vf:10, vsy:2, vb:33, hp:1'b0, vp:1'b0, div:4};
        mc = '{ha:4, hf:1, hsy:2, hb:1, va:3, vf:1, vsy:1, vb:1, hp:1'b1, vp:1'b1, div:1};

        //            k                h    v   hs vs de hr vr sof
        vecs.push_back(mkv(0,          0,   0,  1, 1, 1, 0, 0, 0));
        vecs.push_back(mkv(639,        639, 0,  1, 1, 1, 0, 0, 0));
        vecs.push_back(mkv(640,        640, 0,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(655,        655, 0,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(656,        656, 0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(751,        751, 0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(752,        752, 0,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(799,        799, 0,  1, 1, 0, 1, 0, 0));
        vecs.push_back(mkv(800,        0,   1,  1, 1, 1, 0, 0, 0));
        vecs.push_back(mkv(5*800+639,  639, 5,  1, 1, 1, 0, 0, 0));
        vecs.push_back(mkv(6*800,      0,   6,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(8*800,      0,   8,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(9*800+751,  751, 9,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(10*800,     0,   10, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(11*800+799, 799, 11, 1, 1, 0, 1, 1, 0));
        vecs.push_back(mkv(12*800,     0,   0,  1, 1, 1, 0, 0, 1));
        vecs.push_back(mkv(12*800+1,   1,   0,  1, 1, 1, 0, 0, 0));

        aclr_a = 1'b1; aclr_b = 1'b1; aclr_c = 1'b1;
        run_a  = 1'b0; run_b  = 1'b0; run_c  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        aclr_a = 1'b0; aclr_b = 1'b0; aclr_c = 1'b0;
        #1;
        compare("rst_a", sample(0), paused(model(ma, 0)));
        compare("rst_b", sample(1), paused(model(mb, 0)));
        compare("rst_c", sample(2), paused(model(mc, 0)));

        // Instance A: line/frame walk with hand-derived decode points.
        run_a = 1'b1;
        #1;
        ja = 0;
        compare("a_start", sample(0), model(ma, 0));
        foreach (vecs[i]) begin
            while (ja < vecs[i].k) step_check(0, ma, "a", ja);
            compare($sformatf("a_vec%0d", i), sample(0), vecs[i].o);
        end

        // Asynchronous clear mid-frame at HCOORD=700, VCOORD=8 of the second frame.
        while (ja < 12*800 + 8*800 + 700) step_check(0, ma, "a", ja);
        chk("a_preclr.hcoord", int'(hc_a), 700);
        chk("a_preclr.vcoord", int'(vc_a), 8);
        aclr_a = 1'b1;
        #1;
        compare("a_clr_async", sample(0), model(ma, 0));
        repeat (2) begin
            @(posedge clk);
            #2;
            compare("a_clr_hold", sample(0), model(ma, 0));
        end
        @(posedge clk);
        #1;
        aclr_a = 1'b0;
        ja = 0;
        #1;
        compare("a_clr_rel", sample(0), model(ma, 0));
        repeat (40) step_check(0, ma, "a_restart", ja);
        run_a = 1'b0;

        // Instance B: CLK_DIV=4, pause for 7 cycles at HCOORD=100 with div=2.
        run_b = 1'b1;
        #1;
        jb = 0;
        compare("b_start", sample(1), model(mb, 0));
        while (jb < 402) step_check(1, mb, "b", jb);
        chk("b_prepause.hcoord", int'(hc_b), 100);
        run_b = 1'b0;
        #1;
        compare("b_pause0", sample(1), paused(model(mb, jb)));
        repeat (7) begin
            @(posedge clk);
            #2;
            compare("b_pause", sample(1), paused(model(mb, jb)));
        end
        run_b = 1'b1;
        #1;
        compare("b_resume", sample(1), model(mb, jb));
        while (jb < 3208) step_check(1, mb, "b", jb);
        run_b = 1'b0;

        // Instance C: two full tiny frames, active-high syncs.
        run_c = 1'b1;
        #1;
        jc = 0;
        compare("c_start", sample(2), model(mc, 0));
        while (jc < 100) step_check(2, mc, "c", jc);
        run_c = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
